// File: rtl/oven_ctrl.sv
// Oven controller: tick generator, setpoint/bake-time entry, heating model, preheat/bake FSM, BCD display.
// Define OVEN_WALL_CLOCK_EN to show a free-running mm:ss wall clock while the oven is OFF.
module oven_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned TEMP_MIN  = 150,
  parameter int unsigned TEMP_MAX  = 550,
  parameter int unsigned TEMP_INIT = 350,
  parameter int unsigned TEMP_STEP = 5,
  parameter int unsigned TEMP_AMB  = 70,
  parameter int unsigned RAMP      = 5,
  parameter int unsigned HYST      = 5,
  parameter int unsigned TIME_STEP = 15,
  parameter int unsigned TIME_MAX  = 5985
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power,
  input  logic       up_n,
  input  logic       down_n,
  input  logic       start,
  input  logic       time_sel,
  output logic       heat,
  output logic       done,
  output logic [2:0] state,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TEMP_W   = 10;
  localparam int unsigned TIME_W   = 13;
  localparam int unsigned TEMP_CAP = 999;
`ifdef OVEN_WALL_CLOCK_EN
  localparam logic [15:0] DISP_RST = 16'h0000;
`else
  localparam logic [15:0] DISP_RST = 16'hFFFF;
`endif

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_PREHEAT = 3'd2,
    S_BAKE    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                heat_d, done_d;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [2:0]          up_sr, dn_sr, st_sr;
  logic                up_edge, dn_edge, st_edge, adj_up, adj_dn;
  logic [TEMP_W-1:0]   target_q, temp_q, temp_nx;
  logic [TIME_W-1:0]   bake_q, rem_q, rem_d;
  logic [TEMP_W:0]     tgt_inc, temp_inc;
  logic [TIME_W:0]     bake_inc;
  logic [15:0]         disp_d;

  function automatic logic [15:0] temp_bcd(input logic [TEMP_W-1:0] t);
    return {4'hF, 4'(t / 10'd100), 4'((t / 10'd10) % 10'd10), 4'(t % 10'd10)};
  endfunction

  function automatic logic [15:0] time_bcd(input logic [TIME_W-1:0] s);
    logic [6:0] mm;
    logic [5:0] ss;
    mm = 7'(s / 13'd60);
    ss = 6'(s % 13'd60);
    return {4'(mm / 7'd10), 4'(mm % 7'd10), 4'(ss / 6'd10), 4'(ss % 6'd10)};
  endfunction

  // Stage 0/1 synchronise, stage 2 holds the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sr <= 3'b111;
      dn_sr <= 3'b111;
      st_sr <= 3'b000;
    end else begin
      up_sr <= {up_sr[1:0], up_n};
      dn_sr <= {dn_sr[1:0], down_n};
      st_sr <= {st_sr[1:0], start};
    end
  end

  assign up_edge = ~up_sr[1] & up_sr[2];
  assign dn_edge = ~dn_sr[1] & dn_sr[2];
  assign st_edge = st_sr[1] & ~st_sr[2];
  assign adj_up  = up_edge & ~dn_edge & (state_q == S_IDLE);
  assign adj_dn  = dn_edge & ~up_edge & (state_q == S_IDLE);

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  assign tgt_inc  = {1'b0, target_q} + 11'(TEMP_STEP);
  assign bake_inc = {1'b0, bake_q} + 14'(TIME_STEP);

  // Saturating setpoint and bake-time entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= TEMP_W'(TEMP_INIT);
      bake_q   <= '0;
    end else if (!time_sel) begin
      if (adj_up)
        target_q <= (tgt_inc > 11'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : tgt_inc[TEMP_W-1:0];
      else if (adj_dn)
        target_q <= ({1'b0, target_q} < 11'(TEMP_MIN + TEMP_STEP)) ? TEMP_W'(TEMP_MIN)
                                                                    : target_q - TEMP_W'(TEMP_STEP);
    end else begin
      if (adj_up)
        bake_q <= (bake_inc > 14'(TIME_MAX)) ? TIME_W'(TIME_MAX) : bake_inc[TIME_W-1:0];
      else if (adj_dn)
        bake_q <= (bake_q < TIME_W'(TIME_STEP)) ? '0 : bake_q - TIME_W'(TIME_STEP);
    end
  end

  assign temp_inc = {1'b0, temp_q} + 11'(RAMP);

  always_comb begin
    temp_nx = TEMP_W'(TEMP_AMB);
    if (heat)
      temp_nx = (temp_inc > 11'(TEMP_CAP)) ? TEMP_W'(TEMP_CAP) : temp_inc[TEMP_W-1:0];
    else if (temp_q > TEMP_W'(TEMP_AMB))
      temp_nx = temp_q - TEMP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    temp_q <= TEMP_W'(TEMP_AMB);
    else if (tick) temp_q <= temp_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      heat    <= 1'b0;
      done    <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      heat    <= heat_d;
      done    <= done_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and remaining time; registered outputs follow the next state.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    heat_d  = 1'b0;
    done_d  = 1'b0;
    if (!power) begin
      state_d = S_OFF;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_OFF:  state_d = S_IDLE;
        S_IDLE: begin
          if (st_edge && (bake_q != '0)) begin
            rem_d   = bake_q;
            state_d = S_PREHEAT;
          end
        end
        S_PREHEAT: begin
          if (st_edge)                 state_d = S_IDLE;
          else if (temp_q >= target_q) state_d = S_BAKE;
        end
        S_BAKE: begin
          if (st_edge) begin
            state_d = S_IDLE;
          end else if (tick) begin
            if (rem_q <= TIME_W'(1)) begin
              rem_d   = '0;
              state_d = S_DONE;
            end else begin
              rem_d = rem_q - TIME_W'(1);
            end
          end
        end
        S_DONE:  if (st_edge) state_d = S_IDLE;
        default: state_d = S_OFF;
      endcase
    end
    case (state_d)
      S_PREHEAT: heat_d = 1'b1;
      S_BAKE: begin
        if (({1'b0, temp_q} + 11'(HYST)) < {1'b0, target_q}) heat_d = 1'b1;
        else if (temp_q >= target_q)                       heat_d = 1'b0;
        else                                               heat_d = heat;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef OVEN_WALL_CLOCK_EN
  logic [11:0] wall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    wall_q <= '0;
    else if (tick) wall_q <= (wall_q == 12'd3599) ? '0 : wall_q + 12'd1;
  end
`endif

  always_comb begin
    disp_d = 16'hFFFF;
    case (state_q)
`ifdef OVEN_WALL_CLOCK_EN
      S_OFF:     disp_d = time_bcd(TIME_W'(wall_q));
`else
      S_OFF:     disp_d = 16'hFFFF;
`endif
      S_IDLE:    disp_d = time_sel ? time_bcd(bake_q) : temp_bcd(target_q);
      S_PREHEAT: disp_d = temp_bcd(temp_q);
      S_BAKE:    disp_d = time_bcd(rem_q);
      S_DONE:    disp_d = 16'h0000;
      default:   disp_d = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {d3, d2, d1, d0} <= DISP_RST;
    else        {d3, d2, d1, d0} <= disp_d;
  end

endmodule
